// File: rtl/note_arranger_pkg.sv
// Shared constants, state encoding and helpers for the note arranger and its beat source.
package note_arranger_pkg;

    localparam int unsigned CMD_W      = 16;
    localparam int unsigned ADV_BIT    = 15;
    localparam int unsigned NOTE_MSB   = 14;
    localparam int unsigned NOTE_LSB   = 9;
    localparam int unsigned DUR_MSB    = 8;
    localparam int unsigned DUR_LSB    = 3;
    localparam int unsigned NUM_VOICES = 3;
    localparam int unsigned NOTE_W     = NOTE_MSB - NOTE_LSB + 1;
    localparam int unsigned DUR_W      = DUR_MSB - DUR_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_VOICE = 2'd1,
        ST_REST       = 2'd2
    } arr_state_e;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } voice_cmd_t;

    // One-hot grant of the lowest-numbered voice whose busy flag is clear; zero when all are busy.
    function automatic logic [NUM_VOICES-1:0] lowest_free(input logic [NUM_VOICES-1:0] busy);
        logic [NUM_VOICES-1:0] free;
        free = ~busy;
        return free & (~free + NUM_VOICES'(1));
    endfunction

endpackage

// File: rtl/beat_generator.sv
// Free-running beat source: one-cycle strobe every STOP enabled cycles.
module beat_generator #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STOP  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic beat
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_stop;

    assign at_stop = (cnt_q == WIDTH'(STOP - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = at_stop ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign beat = en && at_stop;

endmodule

// File: rtl/note_arranger.sv
// Dispatches note commands to the lowest free voice and times rest/advance commands in beats.
module note_arranger
    import note_arranger_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load_new_note,
    input  logic [CMD_W-1:0]    note_to_load,
    input  logic                play_enable,
    input  logic                beat,
    output logic                note_1_load,
    output logic [NOTE_W-1:0]   note_1,
    output logic [DUR_W-1:0]    note_1_duration,
    input  logic                note_1_done,
    output logic                note_2_load,
    output logic [NOTE_W-1:0]   note_2,
    output logic [DUR_W-1:0]    note_2_duration,
    input  logic                note_2_done,
    output logic                note_3_load,
    output logic [NOTE_W-1:0]   note_3,
    output logic [DUR_W-1:0]    note_3_duration,
    input  logic                note_3_done,
    output logic                note_done,
    output logic                advance_time
);

    arr_state_e                         state_q, state_d;
    logic [NUM_VOICES-1:0]              busy_q, busy_d;
    logic [DUR_W-1:0]                   rest_q, rest_d;
    voice_cmd_t                         pend_q, pend_d;
    logic [NUM_VOICES-1:0]              load_q, load_d;
    logic [NUM_VOICES-1:0][NOTE_W-1:0]  note_q, note_d;
    logic [NUM_VOICES-1:0][DUR_W-1:0]   dur_q, dur_d;
    logic                               done_q, done_d;
    logic                               adv_q, adv_d;

    logic [NUM_VOICES-1:0]              voice_done;
    logic [NUM_VOICES-1:0]              grant;
    voice_cmd_t                         new_cmd;
    voice_cmd_t                         disp_cmd;
    logic                               dispatch;
    logic                               unused_cmd_bits;

    assign voice_done      = {note_3_done, note_2_done, note_1_done};
    assign grant           = lowest_free(busy_q);
    assign new_cmd         = '{note: note_to_load[NOTE_MSB:NOTE_LSB], dur: note_to_load[DUR_MSB:DUR_LSB]};
    assign unused_cmd_bits = ^note_to_load[DUR_LSB-1:0];

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q & ~voice_done;
        rest_d   = rest_q;
        pend_d   = pend_q;
        load_d   = '0;
        note_d   = note_q;
        dur_d    = dur_q;
        done_d   = 1'b0;
        adv_d    = 1'b0;
        dispatch = 1'b0;
        disp_cmd = pend_q;

        case (state_q)
            ST_IDLE: begin
                if (load_new_note) begin
                    if (note_to_load[ADV_BIT]) begin
                        if (new_cmd.dur == '0) begin
                            adv_d  = 1'b1;
                            done_d = 1'b1;
                        end else begin
                            rest_d  = new_cmd.dur;
                            state_d = ST_REST;
                        end
                    end else if (|grant) begin
                        dispatch = 1'b1;
                        disp_cmd = new_cmd;
                    end else begin
                        pend_d  = new_cmd;
                        state_d = ST_WAIT_VOICE;
                    end
                end
            end
            ST_WAIT_VOICE: begin
                if (|grant) begin
                    dispatch = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_REST: begin
                if (beat && play_enable) begin
                    rest_d = rest_q - DUR_W'(1);
                    if (rest_q == DUR_W'(1)) begin
                        adv_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load to a voice overrides a same-cycle done pulse from that voice.
        if (dispatch) begin
            load_d = grant;
            done_d = 1'b1;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if (grant[v]) begin
                    note_d[v] = disp_cmd.note;
                    dur_d[v]  = disp_cmd.dur;
                    busy_d[v] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= '0;
            rest_q  <= '0;
            pend_q  <= '0;
            load_q  <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            done_q  <= 1'b0;
            adv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            rest_q  <= rest_d;
            pend_q  <= pend_d;
            load_q  <= load_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            done_q  <= done_d;
            adv_q   <= adv_d;
        end
    end

    assign note_1_load     = load_q[0];
    assign note_2_load     = load_q[1];
    assign note_3_load     = load_q[2];
    assign note_1          = note_q[0];
    assign note_2          = note_q[1];
    assign note_3          = note_q[2];
    assign note_1_duration = dur_q[0];
    assign note_2_duration = dur_q[1];
    assign note_3_duration = dur_q[2];
    assign note_done       = done_q;
    assign advance_time    = adv_q;

endmodule

// File: tb/tb_note_arranger.sv
// Directed bench for note_arranger driven by a beat_generator with STOP=10.
module tb_note_arranger;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_new_note = 1'b0;
    logic [15:0] note_to_load = '0;
    logic        play_enable = 1'b1;
    logic        beat;
    logic        note_1_load, note_2_load, note_3_load;
    logic [5:0]  note_1, note_2, note_3;
    logic [5:0]  note_1_duration, note_2_duration, note_3_duration;
    logic        note_1_done = 1'b0, note_2_done = 1'b0, note_3_done = 1'b0;
    logic        note_done, advance_time;
    wire  [2:0]  loads = {note_3_load, note_2_load, note_1_load};

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    beat_generator #(.WIDTH(4), .STOP(10)) u_beat (
        .clk(clk), .reset(reset), .en(1'b1), .beat(beat)
    );

    note_arranger dut (
        .clk(clk), .reset(reset),
        .load_new_note(load_new_note), .note_to_load(note_to_load),
        .play_enable(play_enable), .beat(beat),
        .note_1_load(note_1_load), .note_1(note_1), .note_1_duration(note_1_duration), .note_1_done(note_1_done),
        .note_2_load(note_2_load), .note_2(note_2), .note_2_duration(note_2_duration), .note_2_done(note_2_done),
        .note_3_load(note_3_load), .note_3(note_3), .note_3_duration(note_3_duration), .note_3_done(note_3_done),
        .note_done(note_done), .advance_time(advance_time)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] cmd);
        load_new_note = 1'b1;
        note_to_load  = cmd;
        tick();
        load_new_note = 1'b0;
    endtask

    task automatic wait_beat(output bit found);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (beat) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    function automatic logic [15:0] mk_note(input logic [5:0] n, input logic [5:0] d);
        return {1'b0, n, d, 3'b000};
    endfunction

    function automatic logic [15:0] mk_adv(input logic [5:0] d);
        return {1'b1, 6'd0, d, 3'b000};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, {29'd0, loads[2:0]} | {30'd0, note_done, advance_time}, 0);
        check({tag, "_notes"}, {14'd0, note_1, note_2, note_3}, 0);
        check({tag, "_durs"}, {14'd0, note_1_duration, note_2_duration, note_3_duration}, 0);
    endtask

    initial begin
        bit   found;
        bit   saw;
        int   hit;
        logic adv_at_hit;

        #20 reset = 1'b0;
        #1;
        check_all_zero("reset");
        check("reset_beat", {31'd0, beat}, 0);

        // beat generator period
        wait_beat(found);
        check("beat_sync0", {31'd0, found}, 1);
        hit = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (beat) begin hit = n; break; end
        end
        check("beat_period", hit, 10);

        // 1: first note goes to voice 1
        send(16'b0_101010_111111_000);
        check("t1_loads", {29'd0, loads}, 3'b001);
        check("t1_note1", {26'd0, note_1}, 42);
        check("t1_dur1", {26'd0, note_1_duration}, 63);
        check("t1_done", {31'd0, note_done}, 1);
        check("t1_adv", {31'd0, advance_time}, 0);
        check("t1_v23", {20'd0, note_2, note_3}, 0);
        tick();
        check("t1_strobe_end", {29'd0, loads} | {31'd0, note_done}, 0);
        check("t1_note1_held", {26'd0, note_1}, 42);
        note_1_done = 1'b1;
        tick();
        note_1_done = 1'b0;

        // 5: zero-duration advance
        send(mk_adv(6'd0));
        check("t5_adv", {31'd0, advance_time}, 1);
        check("t5_done", {31'd0, note_done}, 1);
        check("t5_loads", {29'd0, loads}, 0);
        tick();
        check("t5_strobe_end", {30'd0, advance_time, note_done}, 0);

        // 2: three-beat rest, with an ignored note load while resting
        wait_beat(found);
        check("t2_sync", {31'd0, found}, 1);
        send(16'b1_000000_000011_000);
        hit = 0; saw = 1'b0; adv_at_hit = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (|loads) saw = 1'b1;
            if (note_done) begin hit = n; adv_at_hit = advance_time; break; end
            load_new_note = (n == 5);
            note_to_load  = mk_note(6'd7, 6'd7);
        end
        load_new_note = 1'b0;
        check("t2_latency", hit, 30);
        check("t2_adv", {31'd0, adv_at_hit}, 1);
        check("t2_no_loads", {31'd0, saw}, 0);
        tick();
        check("t2_strobe_end", {30'd0, advance_time, note_done}, 0);

        // 3: fill all voices, then stall until voice 2 frees up
        send(mk_note(6'd10, 6'd1));
        check("t3_a_loads", {29'd0, loads}, 3'b001);
        check("t3_a_note", {26'd0, note_1}, 10);
        send(mk_note(6'd20, 6'd2));
        check("t3_b_loads", {29'd0, loads}, 3'b010);
        check("t3_b_note", {20'd0, note_1, note_2}, {6'd10, 6'd20});
        send(mk_note(6'd30, 6'd3));
        check("t3_c_loads", {29'd0, loads}, 3'b100);
        check("t3_c_note", {26'd0, note_3}, 30);
        send(mk_note(6'd40, 6'd4));
        saw = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (note_done || (|loads)) saw = 1'b1;
            tick();
        end
        check("t3_stall", {31'd0, saw}, 0);
        note_2_done = 1'b1;
        tick();
        note_2_done = 1'b0;
        check("t3_not_yet", {29'd0, loads}, 0);
        tick();
        check("t3_d_loads", {29'd0, loads}, 3'b010);
        check("t3_d_note", {20'd0, note_2, note_2_duration}, {6'd40, 6'd4});
        check("t3_d_done", {31'd0, note_done}, 1);
        check("t3_d_others", {20'd0, note_1, note_3}, {6'd10, 6'd30});
        tick();
        check("t3_strobe_end", {29'd0, loads} | {31'd0, note_done}, 0);

        // load wins over a same-cycle done on the loaded voice
        note_1_done = 1'b1;
        tick();
        load_new_note = 1'b1;
        note_to_load  = mk_note(6'd50, 6'd5);
        tick();
        load_new_note = 1'b0;
        note_1_done   = 1'b0;
        check("lw_loads", {29'd0, loads}, 3'b001);
        check("lw_note", {26'd0, note_1}, 50);
        send(mk_note(6'd60, 6'd6));
        check("lw_stall", {29'd0, loads} | {31'd0, note_done}, 0);

        // 6a: reset while waiting for a voice
        tick();
        reset = 1'b1;
        #1;
        check_all_zero("rst_wait");
        tick();
        reset = 1'b0;
        send(mk_note(6'd11, 6'd12));
        check("rst_wait_v1", {29'd0, loads}, 3'b001);
        check("rst_wait_note", {20'd0, note_1, note_1_duration}, {6'd11, 6'd12});
        send(mk_note(6'd12, 6'd1));
        check("rst_wait_v2", {29'd0, loads}, 3'b010);

        // 4: five-beat rest with play_enable low for 40 clocks
        wait_beat(found);
        check("t4_sync", {31'd0, found}, 1);
        send(mk_adv(6'd5));
        play_enable = 1'b0;
        hit = 0; adv_at_hit = 1'b0;
        for (int n = 1; n <= 150; n++) begin
            tick();
            if (n == 40) play_enable = 1'b1;
            if (note_done) begin hit = n; adv_at_hit = advance_time; break; end
        end
        play_enable = 1'b1;
        check("t4_latency", hit, 90);
        check("t4_adv", {31'd0, adv_at_hit}, 1);

        // 6b: reset during a rest aborts it
        send(mk_adv(6'd5));
        for (int n = 0; n < 20; n++) tick();
        reset = 1'b1;
        #1;
        check_all_zero("rst_rest");
        tick();
        reset = 1'b0;
        saw = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (note_done || advance_time) saw = 1'b1;
        end
        check("rst_rest_aborted", {31'd0, saw}, 0);
        send(mk_note(6'd33, 6'd3));
        check("rst_rest_v1", {29'd0, loads}, 3'b001);
        check("rst_rest_note", {26'd0, note_1}, 33);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
